memory_responder: RTL

MEMORY_RESPONDER -- requirements
Module: memory_responder

---
 rtl/memory_responder_pkg.sv | 18 +
 rtl/memory_responder_word_ram.sv | 40 ++++
 rtl/memory_responder.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/memory_responder_pkg.sv
// memory_responder_pkg
//   Shared definitions for the memory responder and its bus masters.
//   - bus_resp_t : data-phase response code (RESP_OKAY / RESP_ERROR)
//   - rom_word() : fixed storage contents used when the block is built
//                  as a ROM (MEMORY_RESPONDER_WRITE_EN undefined)
package memory_responder_pkg;

    typedef enum logic {
        RESP_OKAY  = 1'b0,
        RESP_ERROR = 1'b1
    } bus_resp_t;

    // ROM image: a recognisable tag in the upper half, word index below.
    function automatic logic [31:0] rom_word(input logic [31:0] idx);
        return 32'hC0DE_0000 | idx;
    endfunction

endpackage

// File: rtl/memory_responder_word_ram.sv
// word_ram
//   DEPTH_WORDS x 32 storage: synchronous write, combinational read.
//   Ports:
//     clk_i, we_i, waddr_i, wdata_i : write port (MEMORY_RESPONDER_WRITE_EN only)
//     raddr_i                       : read word index
//     rdata_o                       : read word, combinational from raddr_i
//   With MEMORY_RESPONDER_WRITE_EN undefined there is no write port and the
//   contents come from memory_responder_pkg::rom_word().
module word_ram
    import memory_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
`ifdef MEMORY_RESPONDER_WRITE_EN
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  logic [31:0]      wdata_i,
`endif
    input  logic [IDX_W-1:0] raddr_i,
    output logic [31:0]      rdata_o
);

`ifdef MEMORY_RESPONDER_WRITE_EN
    logic [31:0] mem_q [DEPTH_WORDS];

    // No reset: contents survive a responder reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];
`else
    assign rdata_o = rom_word(32'(raddr_i));
`endif

endmodule

// File: rtl/memory_responder.sv
// memory_responder
//   Single-port bus memory slave with configurable wait states and a
//   two-cycle ERROR response for bad addresses.
//   Parameters: BASE_ADDR (first decoded byte), DEPTH_WORDS (power of two,
//   >= 4), WAIT_STATES (0..15 stall cycles before each OKAY data phase).
//   Ports:
//     clk_i, rst_ni             : clock, async active-low reset
//     sel_i, start_i            : select and address-phase request
//     address_i, write_i        : byte address and direction (with start_i)
//     write_data_i              : write data, valid in the data phase
//     ready_o, response_o       : data-phase handshake and response code
//     read_data_o               : read word, valid in an OKAY read DATA cycle
//   Macro MEMORY_RESPONDER_WRITE_EN: when defined writes update storage;
//   when undefined every write is an error and storage is a ROM.
module memory_responder
    import memory_responder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        sel_i,
    input  logic        start_i,
    input  logic [31:0] address_i,
    input  logic        write_i,
    input  logic [31:0] write_data_i,
    output logic        ready_o,
    output bus_resp_t   response_o,
    output logic [31:0] read_data_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN  = 33'(DEPTH_WORDS) << 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_STALL,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             wr_q, wr_d;
    logic             ready_q, ready_d;
    bus_resp_t        resp_q, resp_d;
    logic [31:0]      rdata_q, rdata_d;

    logic [31:0]      offset;
    logic             accept;
    logic             addr_err;
    logic             xfer_err;
    logic [IDX_W-1:0] acc_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [31:0]      ram_rdata;
    logic [31:0]      fwd_rdata;

    assign offset   = address_i - BASE_ADDR;
    assign acc_idx  = offset[IDX_W+1:2];
    assign addr_err = (address_i < BASE_ADDR) || ({1'b0, offset} >= SPAN)
                   || (address_i[1:0] != 2'b00);
    // ERR2 drives ready=1 but must not accept; only IDLE and DATA do.
    assign accept   = sel_i && start_i && (state_q == S_IDLE || state_q == S_DATA);

    // The read port serves whichever transfer enters DATA at the next edge:
    // the one being accepted now, or the one finishing its stall.
    assign rd_idx   = (state_q == S_STALL) ? idx_q : acc_idx;

`ifdef MEMORY_RESPONDER_WRITE_EN
    logic ram_we;

    assign xfer_err = addr_err;
    assign ram_we   = (state_q == S_DATA) && wr_q;
    // A chained read entering DATA on the same edge that commits a write
    // would see the old word through the combinational port; bypass it.
    assign fwd_rdata = (ram_we && rd_idx == idx_q) ? write_data_i : ram_rdata;

    word_ram #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (ram_we),
        .waddr_i (idx_q),
        .wdata_i (write_data_i),
        .raddr_i (rd_idx),
        .rdata_o (ram_rdata)
    );
`else
    logic unused_wdata;

    assign xfer_err     = addr_err || write_i;
    assign fwd_rdata    = ram_rdata;
    assign unused_wdata = ^write_data_i;

    word_ram #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_ram (
        .raddr_i (rd_idx),
        .rdata_o (ram_rdata)
    );
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wr_d    = wr_q;
        rdata_d = rdata_q;

        unique case (state_q)
            S_IDLE, S_DATA: begin
                if (accept) begin
                    idx_d = acc_idx;
                    wr_d  = write_i;
                    if (xfer_err) begin
                        state_d = S_ERR1;
                    end else if (WAIT_STATES == 0) begin
                        state_d = S_DATA;
                    end else begin
                        state_d = S_STALL;
                        cnt_d   = 4'(WAIT_STATES - 1);
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_STALL: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ERR1:  state_d = S_ERR2;
            S_ERR2:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the next state so they change with it.
        if (state_d == S_DATA && !wr_d) begin
            rdata_d = fwd_rdata;
        end
        ready_d = !(state_d inside {S_STALL, S_ERR1});
        resp_d  = (state_d inside {S_ERR1, S_ERR2}) ? RESP_ERROR : RESP_OKAY;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            ready_q <= 1'b1;
            resp_q  <= RESP_OKAY;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
            ready_q <= ready_d;
            resp_q  <= resp_d;
            rdata_q <= rdata_d;
        end
    end

    assign ready_o     = ready_q;
    assign response_o  = resp_q;
    assign read_data_o = rdata_q;

endmodule
